// File: rtl/mem_wb_if.sv
// MEM/WB boundary bus: MEM-stage instruction fields in, registered writeback fields out.
interface mem_wb_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic             stall;
    logic             flush;
    logic             in_valid;
    logic [XLEN-1:0]  mem_read_data;
    logic [XLEN-1:0]  alu_result;
    logic [2:0]       funct3;
    logic [4:0]       rd;
    logic             reg_write;
    logic             mem_to_reg;

    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic             wb_reg_write;
    logic [XLEN-1:0]  wb_data;
    logic             wb_load_fault;
    logic [CNT_W-1:0] retire_count;

    modport master (
        output stall, flush, in_valid, mem_read_data, alu_result, funct3, rd,
               reg_write, mem_to_reg,
        input  wb_valid, wb_rd, wb_reg_write, wb_data, wb_load_fault, retire_count
    );

    modport slave (
        input  stall, flush, in_valid, mem_read_data, alu_result, funct3, rd,
               reg_write, mem_to_reg,
        output wb_valid, wb_rd, wb_reg_write, wb_data, wb_load_fault, retire_count
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: RV64I load extraction/extension, misaligned-load
// detection, stall/flush handling and a retired-instruction counter.
module mem_wb_stage #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input logic       clk,
    input logic       reset,
    mem_wb_if.slave   bus
);
    logic             valid_q, valid_d;
    logic [4:0]       rd_q, rd_d;
    logic             reg_write_q, reg_write_d;
    logic [XLEN-1:0]  data_q, data_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [2:0]       off;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  load_val;
    logic             unsigned_ld;
    logic             misalign;
    logic             illegal;
    logic             fault;

    // Shift the addressed lane down to bit 0, then extend by access size.
    always_comb begin
        off         = bus.alu_result[2:0];
        shifted     = bus.mem_read_data >> {off, 3'b000};
        unsigned_ld = bus.funct3[2];
        load_val    = '0;
        misalign    = 1'b0;
        illegal     = 1'b0;
        case (bus.funct3[1:0])
            2'b00: load_val = {{(XLEN-8){~unsigned_ld & shifted[7]}}, shifted[7:0]};
            2'b01: begin
                load_val = {{(XLEN-16){~unsigned_ld & shifted[15]}}, shifted[15:0]};
                misalign = off[0];
            end
            2'b10: begin
                load_val = {{(XLEN-32){~unsigned_ld & shifted[31]}}, shifted[31:0]};
                misalign = (off[1:0] != 2'b00);
            end
            default: begin
                load_val = shifted;
                misalign = (off != 3'b000);
                illegal  = unsigned_ld;
            end
        endcase
        fault = bus.mem_to_reg & (misalign | illegal);
    end

    always_comb begin
        valid_d     = valid_q;
        rd_d        = rd_q;
        reg_write_d = reg_write_q;
        data_d      = data_q;
        fault_d     = fault_q;
        cnt_d       = cnt_q;
        if (bus.flush) begin
            valid_d     = 1'b0;
            rd_d        = '0;
            reg_write_d = 1'b0;
            data_d      = '0;
            fault_d     = 1'b0;
        end else if (!bus.stall) begin
            valid_d     = bus.in_valid;
            rd_d        = bus.in_valid ? bus.rd : 5'd0;
            reg_write_d = bus.in_valid & bus.reg_write & (bus.rd != 5'd0) & ~fault;
            fault_d     = bus.in_valid & fault;
            if (!bus.in_valid || fault)
                data_d = '0;
            else if (bus.mem_to_reg)
                data_d = load_val;
            else
                data_d = bus.alu_result;
            // Faulting loads still retire; the counter wraps silently.
            cnt_d = cnt_q + CNT_W'(bus.in_valid);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            data_q      <= '0;
            fault_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            valid_q     <= valid_d;
            rd_q        <= rd_d;
            reg_write_q <= reg_write_d;
            data_q      <= data_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.wb_valid      = valid_q;
    assign bus.wb_rd         = rd_q;
    assign bus.wb_reg_write  = reg_write_q;
    assign bus.wb_data       = data_q;
    assign bus.wb_load_fault = fault_q;
    assign bus.retire_count  = cnt_q;
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline boundary directly downstream of the data memory.
- Takes the full 64-bit doubleword the memory returns, plus the EX/MEM-forwarded address/ALU result and control.
- Extracts and extends the addressed byte/half/word/double (RV64I loads), or selects the ALU result, then registers the result for writeback.
- Also carries stall/flush control, misaligned-load detection and a retired-instruction counter.

Parameters:
- XLEN, 64, datapath width; only 64 supported.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold all WB registers and counter
- flush  input  1  replace incoming instruction with a bubble
- in_valid  input  1  instruction present in MEM
- mem_read_data  input  64  doubleword from data memory (already selected by address[8:3])
- alu_result  input  64  ALU result / effective address
- funct3  input  3  load type
- rd  input  5  destination register
- reg_write  input  1  instruction writes rd
- mem_to_reg  input  1  1 = load, 0 = ALU result
- wb_valid  output  1  registered valid
- wb_rd  output  5  registered rd
- wb_reg_write  output  1  registered, qualified write enable
- wb_data  output  64  registered writeback data
- wb_load_fault  output  1  registered misaligned/illegal-load flag
- retire_count  output  CNT_W  count of valid instructions latched into WB

Behaviour:
- Reset: on posedge clk with reset=1, all outputs clear to 0: wb_valid, wb_rd, wb_reg_write, wb_data, wb_load_fault, retire_count.
- Update priority each posedge: reset > flush > stall > load.
  - flush=1: registers get a bubble (all outputs 0 except retire_count, which holds), regardless of stall.
  - stall=1 (no flush): every register, including retire_count, holds.
  - Otherwise: registers load the next values below.
- Latency: one cycle from inputs to wb_* outputs. No combinational path from inputs to outputs.
- in_valid=0 loads a bubble: wb_valid=0, wb_reg_write=0, wb_load_fault=0, wb_rd=0, wb_data=0.
- Byte offset is off = alu_result[2:0]. Memory is little-endian: byte k is mem_read_data[8k+7:8k].
- Load extraction when mem_to_reg=1:
  - 000 LB: byte[off], sign-extended.
  - 001 LH: half at bytes off..off+1, sign-extended; requires off[0]=0.
  - 010 LW: word at bytes off..off+3, sign-extended; requires off[1:0]=0.
  - 011 LD: whole doubleword; requires off=0.
  - 100 LBU: byte[off], zero-extended.
  - 101 LHU: as LH, zero-extended.
  - 110 LWU: as LW, zero-extended.
  - 111: illegal.
- Fault condition: a misaligned offset or funct3=111 sets fault.
  - On fault: wb_data=0, wb_reg_write=0, wb_load_fault=1; wb_valid and wb_rd still latch.
- mem_to_reg=0: wb_data=alu_result, wb_load_fault=0, funct3 ignored.
- wb_reg_write = reg_write & in_valid & (rd!=0) & ~fault. rd=0 never asserts write.
- retire_count increments by 1 on each non-stalled, non-flushed, non-reset edge with in_valid=1.
  - Faulting loads still count.
  - Wraps from 2^CNT_W-1 to 0 silently.
- Reset mid-stall or mid-flush: reset wins; the next edge with reset=0 behaves normally.

Test Plan:
- Reset then idle: assert reset 2 cycles with random inputs -> all outputs 0 and retire_count=0; after release with in_valid=0, outputs stay 0.
- Byte loads: mem_read_data=0x8877665544332211, mem_to_reg=1, rd=5, reg_write=1:
  - LB off=3 -> wb_data=0x44.
  - LB off=7 -> 0xFFFFFFFFFFFFFF88.
  - LBU off=7 -> 0x88.
  - Each case: wb_reg_write=1, one cycle latency.
- Wider loads, same data:
  - LH off=6 -> 0xFFFFFFFFFFFF8877.
  - LW off=4 -> 0xFFFFFFFF88776655.
  - LWU off=4 -> 0x0000000088776655.
  - LD off=0 -> 0x8877665544332211.
- Faults:
  - LH off=3 -> wb_load_fault=1, wb_data=0, wb_reg_write=0, retire_count+1.
  - funct3=111 -> same fault response.
  - ALU op with rd=0, alu_result=0x1234 -> wb_data=0x1234, wb_reg_write=0.
- Stall/flush:
  - Hold stall=1 for 3 cycles while changing inputs -> outputs and retire_count frozen.
  - stall=1 and flush=1 together -> bubble, count unchanged.
  - Deassert both -> next valid ALU op latches.
- Counter wrap: CNT_W=4, retire 17 valid instructions -> retire_count=1.
